// File: rtl/adc_datain_pkg.sv
// Shared types and constants for the I2S ADC capture stage.
package adc_datain_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSkip,
        StShift,
        StHold
    } state_e;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/adc_datain_if.sv
// Codec-side serial pins plus the parallel sample outputs of the capture stage.
interface adc_datain_if
    import adc_datain_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);
    logic                    bclk;
    logic                    lrclk;
    logic                    adc_dat;
    logic signed [WIDTH-1:0] dataL;
    logic signed [WIDTH-1:0] dataR;
    logic                    valid;
    logic                    frame_err;

    modport master (
        output bclk, lrclk, adc_dat,
        input  dataL, dataR, valid, frame_err
    );

    modport slave (
        input  bclk, lrclk, adc_dat,
        output dataL, dataR, valid, frame_err
    );
endinterface

// File: rtl/adc_datain_sync_edge.sv
// Multi-stage synchronizer with a registered edge pulse; o_level is the level
// the input moved to, valid in the same cycle as o_edge.
module adc_datain_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_edge
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_edge;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] ^ r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_edge  = r_edge;

endmodule

// File: rtl/adc_datain.sv
// I2S receiver for the WM8731 ADC: captures one left/right pair per LRCK frame
// and strobes valid when both channels of a frame arrived complete.
module adc_datain
    import adc_datain_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic         CLK,
    input logic         RST_N,
    adc_datain_if.slave io_bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    logic w_bclk_level, w_bclk_edge, w_bclk_rise;
    logic w_lr_level, w_lr_edge;
    logic w_dat;
    logic [SYNC_STAGES-1:0] r_dat_sync;

    state_e           r_state, w_state_d;
    logic [CntW-1:0]  r_bit_cnt, w_bit_cnt_d;
    logic             r_ch, w_ch_d;
    logic [WIDTH-2:0] r_shift, w_shift_d;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] r_left_stage, w_left_stage_d;
    logic             r_left_ok, w_left_ok_d;
    logic [WIDTH-1:0] r_dataL, w_dataL_d;
    logic [WIDTH-1:0] r_dataR, w_dataR_d;
    logic             r_valid, w_valid_d;
    logic             r_frame_err, w_frame_err_d;

    adc_datain_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_d     (io_bus.bclk),
        .o_level (w_bclk_level),
        .o_edge  (w_bclk_edge)
    );

    adc_datain_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_d     (io_bus.lrclk),
        .o_level (w_lr_level),
        .o_edge  (w_lr_edge)
    );

    // Data skips the edge-detect stage so it lines up with the registered bclk rise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dat_sync <= '0;
        end else begin
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], io_bus.adc_dat};
        end
    end

    assign w_dat       = r_dat_sync[SYNC_STAGES-1];
    assign w_bclk_rise = w_bclk_edge & w_bclk_level;
    assign w_word      = {r_shift, w_dat};

    always_comb begin
        w_state_d      = r_state;
        w_bit_cnt_d    = r_bit_cnt;
        w_ch_d         = r_ch;
        w_shift_d      = r_shift;
        w_left_stage_d = r_left_stage;
        w_left_ok_d    = r_left_ok;
        w_dataL_d      = r_dataL;
        w_dataR_d      = r_dataR;
        w_valid_d      = 1'b0;
        w_frame_err_d  = 1'b0;

        // An lrclk edge always restarts the channel, even if bclk rose in the same cycle.
        if (w_lr_edge) begin
            if (r_state == StSkip || r_state == StShift) begin
                w_frame_err_d = 1'b1;
            end
            if (w_lr_level == CH_LEFT) begin
                w_left_ok_d = 1'b0;
            end
            w_state_d   = StSkip;
            w_ch_d      = w_lr_level;
            w_bit_cnt_d = '0;
        end else if (w_bclk_rise) begin
            case (r_state)
                StSkip: w_state_d = StShift;
                StShift: begin
                    w_shift_d   = w_word[WIDTH-2:0];
                    w_bit_cnt_d = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == LastBit) begin
                        w_state_d = StHold;
                        if (r_ch == CH_LEFT) begin
                            w_left_stage_d = w_word;
                            w_left_ok_d    = 1'b1;
                        end else if (r_ch == CH_RIGHT && r_left_ok) begin
                            w_dataL_d = r_left_stage;
                            w_dataR_d = w_word;
                            w_valid_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= StIdle;
            r_bit_cnt    <= '0;
            r_ch         <= CH_LEFT;
            r_shift      <= '0;
            r_left_stage <= '0;
            r_left_ok    <= 1'b0;
            r_dataL      <= '0;
            r_dataR      <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_bit_cnt    <= w_bit_cnt_d;
            r_ch         <= w_ch_d;
            r_shift      <= w_shift_d;
            r_left_stage <= w_left_stage_d;
            r_left_ok    <= w_left_ok_d;
            r_dataL      <= w_dataL_d;
            r_dataR      <= w_dataR_d;
            r_valid      <= w_valid_d;
            r_frame_err  <= w_frame_err_d;
        end
    end

    assign io_bus.dataL     = r_dataL;
    assign io_bus.dataR     = r_dataR;
    assign io_bus.valid     = r_valid;
    assign io_bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_adc_datain.sv
// Directed bench for adc_datain: drives I2S frames and checks captured samples.
module tb_adc_datain;
    localparam int unsigned Width    = 16;
    localparam int unsigned Sync     = 2;
    localparam int          BclkHalf = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    adc_datain_if #(.WIDTH(Width)) bus_if ();

    adc_datain #(.WIDTH(Width), .SYNC_STAGES(Sync)) dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .io_bus (bus_if)
    );

    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int v_cyc = 0;
    int t_lsb = 0;
    int n_checks = 0;
    int n_fail = 0;
    int v0, f0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.valid) begin
            n_valid <= n_valid + 1;
            v_cyc   <= cyc;
        end
        if (bus_if.frame_err) n_ferr <= n_ferr + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One channel: slots bclk periods; data MSB lands on slot 'skip'.
    // coinc moves the lrclk change onto the slot-0 bclk rise.
    task automatic send_ch(input logic lvl, input logic [31:0] data, input int nbits,
                           input int slots, input int skip, input bit coinc,
                           input int rel_slot);
        for (int k = 0; k < slots; k++) begin
            @(negedge clk);
            bus_if.bclk = 1'b0;
            if (k == 0 && !coinc) bus_if.lrclk = lvl;
            if (k == rel_slot) rst_n = 1'b1;
            if (k >= skip && (k - skip) < nbits) bus_if.adc_dat = data[nbits-1-(k-skip)];
            else bus_if.adc_dat = 1'b0;
            repeat (BclkHalf - 1) @(negedge clk);
            bus_if.bclk = 1'b1;
            if (k == 0 && coinc) bus_if.lrclk = lvl;
            if (k == skip + nbits - 1) t_lsb = cyc;
            repeat (BclkHalf - 1) @(negedge clk);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus_if.bclk    = 1'b0;
        bus_if.lrclk   = 1'b0;
        bus_if.adc_dat = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_dataL", $unsigned(bus_if.dataL), 32'h0);
        check_eq("rst_dataR", $unsigned(bus_if.dataR), 32'h0);
        check_eq("rst_valid", 32'(bus_if.valid), 32'h0);
        check_eq("rst_ferr", 32'(bus_if.frame_err), 32'h0);
        rst_n = 1'b1;

        // Basic frame, preceded by a right channel that only leaves IDLE.
        send_ch(1'b1, 32'h5555, 16, 20, 1, 1'b0, -1);
        send_ch(1'b0, 32'h1234, 16, 20, 1, 1'b0, -1);
        send_ch(1'b1, 32'h8001, 16, 20, 1, 1'b0, -1);
        settle();
        check_eq("t1_nvalid", n_valid, 1);
        check_eq("t1_dataL", $unsigned(bus_if.dataL), 32'h1234);
        check_eq("t1_dataR", $unsigned(bus_if.dataR), 32'h8001);
        check_eq("t1_dataR_signed", 32'(int'(bus_if.dataR)), 32'hFFFF_8001);
        check_eq("t1_latency", v_cyc - t_lsb, Sync + 2);
        check_eq("t1_nferr", n_ferr, 0);

        // Reset released mid-left: partial frame must not produce valid.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t2_async_dataL", $unsigned(bus_if.dataL), 32'h0);
        check_eq("t2_async_dataR", $unsigned(bus_if.dataR), 32'h0);
        v0 = n_valid;
        f0 = n_ferr;
        send_ch(1'b0, 32'h7777, 16, 20, 1, 1'b0, 5);
        send_ch(1'b1, 32'h2222, 16, 20, 1, 1'b0, -1);
        settle();
        check_eq("t2_partial_nvalid", n_valid - v0, 0);
        send_ch(1'b0, 32'h7FFF, 16, 20, 1, 1'b0, -1);
        send_ch(1'b1, 32'h0000, 16, 20, 1, 1'b0, -1);
        settle();
        check_eq("t2_nvalid", n_valid - v0, 1);
        check_eq("t2_dataL", $unsigned(bus_if.dataL), 32'h7FFF);
        check_eq("t2_dataR", $unsigned(bus_if.dataR), 32'h0000);
        check_eq("t2_nferr", n_ferr - f0, 0);

        // 24-bit codec words: low bits ignored.
        v0 = n_valid;
        f0 = n_ferr;
        send_ch(1'b0, 32'hABCDEF, 24, 32, 1, 1'b0, -1);
        send_ch(1'b1, 32'h123456, 24, 32, 1, 1'b0, -1);
        settle();
        check_eq("t3_nvalid", n_valid - v0, 1);
        check_eq("t3_dataL", $unsigned(bus_if.dataL), 32'hABCD);
        check_eq("t3_dataR", $unsigned(bus_if.dataR), 32'h1234);
        check_eq("t3_nferr", n_ferr - f0, 0);

        // Short left channel (10 bits).
        v0 = n_valid;
        f0 = n_ferr;
        send_ch(1'b0, 32'h2AB, 10, 11, 1, 1'b0, -1);
        send_ch(1'b1, 32'h4444, 16, 20, 1, 1'b0, -1);
        settle();
        check_eq("t4_ferr_pulse", n_ferr - f0, 1);
        check_eq("t4_no_valid", n_valid - v0, 0);
        check_eq("t4_dataL_held", $unsigned(bus_if.dataL), 32'hABCD);
        send_ch(1'b0, 32'h0F0F, 16, 20, 1, 1'b0, -1);
        send_ch(1'b1, 32'hF0F0, 16, 20, 1, 1'b0, -1);
        settle();
        check_eq("t4_nvalid", n_valid - v0, 1);
        check_eq("t4_dataL", $unsigned(bus_if.dataL), 32'h0F0F);
        check_eq("t4_dataR", $unsigned(bus_if.dataR), 32'hF0F0);
        check_eq("t4_nferr", n_ferr - f0, 1);

        // lrclk edge coincident with a bclk rise: that rise is dropped.
        v0 = n_valid;
        f0 = n_ferr;
        send_ch(1'b0, 32'h1357, 16, 20, 1, 1'b0, -1);
        send_ch(1'b1, 32'h2468, 16, 20, 2, 1'b1, -1);
        settle();
        check_eq("t5_nvalid", n_valid - v0, 1);
        check_eq("t5_dataL", $unsigned(bus_if.dataL), 32'h1357);
        check_eq("t5_dataR", $unsigned(bus_if.dataR), 32'h2468);
        check_eq("t5_nferr", n_ferr - f0, 0);

        // Reset between left-complete and right-complete.
        send_ch(1'b0, 32'h5A5A, 16, 20, 1, 1'b0, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_dataL", $unsigned(bus_if.dataL), 32'h0);
        check_eq("t6_async_dataR", $unsigned(bus_if.dataR), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid;
        f0 = n_ferr;
        send_ch(1'b1, 32'h6666, 16, 20, 1, 1'b0, -1);
        settle();
        check_eq("t6_no_stale", n_valid - v0, 0);
        send_ch(1'b0, 32'h0102, 16, 20, 1, 1'b0, -1);
        send_ch(1'b1, 32'h0304, 16, 20, 1, 1'b0, -1);
        settle();
        check_eq("t6_nvalid", n_valid - v0, 1);
        check_eq("t6_dataL", $unsigned(bus_if.dataL), 32'h0102);
        check_eq("t6_dataR", $unsigned(bus_if.dataR), 32'h0304);
        check_eq("t6_nferr", n_ferr - f0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
